// File: rtl/gametank_pkg.sv
// Shared definitions for the GameTank blitter: register map, CTRL bits, FSM states.
package gametank_pkg;

    localparam logic [2:0] REG_VX     = 3'd0;
    localparam logic [2:0] REG_VY     = 3'd1;
    localparam logic [2:0] REG_GX     = 3'd2;
    localparam logic [2:0] REG_GY     = 3'd3;
    localparam logic [2:0] REG_WIDTH  = 3'd4;
    localparam logic [2:0] REG_HEIGHT = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_COLOR  = 3'd7;

    localparam int CTRL_START    = 0;
    localparam int CTRL_FILL     = 1;
    localparam int CTRL_OPAQUE   = 2;
    localparam int CTRL_BANK_SEL = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/gametank_blitter_if.sv
// CPU register window, IRQ and GRAM/framebuffer memory ports of the blitter.
interface gametank_blitter_if #(
    parameter int BANK_W = 3,
    parameter int FB_AW  = 14
);
    logic                ce;
    logic                reg_we;
    logic [2:0]          reg_addr;
    logic [7:0]          reg_din;
    logic                busy;
    logic                irq_done;
    logic                irq_ack;
    logic [BANK_W+15:0]  gram_addr;
    logic                gram_rd;
    logic [7:0]          gram_din;
    logic [FB_AW-1:0]    fb_addr;
    logic                fb_we;
    logic [7:0]          fb_dout;

    modport slave (
        input  ce, reg_we, reg_addr, reg_din, irq_ack, gram_din,
        output busy, irq_done, gram_addr, gram_rd, fb_addr, fb_we, fb_dout
    );

    modport master (
        output ce, reg_we, reg_addr, reg_din, irq_ack, gram_din,
        input  busy, irq_done, gram_addr, gram_rd, fb_addr, fb_we, fb_dout
    );
endinterface

// File: rtl/gametank_blit_addr.sv
// Pixel coordinate calculation: optional flip, 8-bit wrapped coordinate,
// linear framebuffer address and off-screen clip flag from the 9-bit sum.
module gametank_blit_addr #(
    parameter int FB_W  = 128,
    parameter int FB_H  = 128,
    parameter int FB_AW = 14
) (
    input  logic [7:0]       base_x_i,
    input  logic [7:0]       base_y_i,
    input  logic [6:0]       i_i,
    input  logic [6:0]       j_i,
    input  logic [6:0]       w_i,
    input  logic [6:0]       h_i,
    input  logic             flip_x_i,
    input  logic             flip_y_i,
    output logic [7:0]       sx_o,
    output logic [7:0]       sy_o,
    output logic [FB_AW-1:0] fb_addr_o,
    output logic             clip_o
);
    localparam int XW = $clog2(FB_W);
    localparam int YW = FB_AW - XW;

    logic [6:0] off_x, off_y;
    logic [8:0] sum_x, sum_y;

    assign off_x = flip_x_i ? (w_i - 7'd1 - i_i) : i_i;
    assign off_y = flip_y_i ? (h_i - 7'd1 - j_i) : j_i;
    assign sum_x = {1'b0, base_x_i} + {2'b00, off_x};
    assign sum_y = {1'b0, base_y_i} + {2'b00, off_y};

    assign sx_o      = sum_x[7:0];
    assign sy_o      = sum_y[7:0];
    assign fb_addr_o = {sum_y[YW-1:0], sum_x[XW-1:0]};
    assign clip_o    = (sum_x >= 9'(FB_W)) || (sum_y >= 9'(FB_H));

endmodule

// File: rtl/gametank_blitter.sv
// GameTank blitter: two-stage (read, write) rectangular copy/fill engine.
//   state | meaning
//   IDLE  | registers writable, waiting for START
//   RUN   | one source pixel issued per ce, previous pixel written
//   DRAIN | last pixel written on next ce, then completion IRQ
module gametank_blitter
    import gametank_pkg::*;
#(
    parameter int FB_W   = 128,
    parameter int FB_H   = 128,
    parameter int BANK_W = 3,
    parameter int FB_AW  = 14
) (
    input  logic              clk,
    input  logic              reset_gametank,
    gametank_blitter_if.slave bus
);
    logic [7:0]        vx_q, vy_q, gx_q, gy_q, color_q;
    logic [6:0]        w_q, h_q;
    logic              flipx_q, flipy_q, fill_q, opaque_q, bank_sel_q;
    logic [BANK_W-1:0] bank_q;

    state_e     state_q, state_d;
    logic [6:0] i_q, i_d, j_q, j_d, p_i_q, p_i_d, p_j_q, p_j_d;
    logic       p_valid_q, p_valid_d, irq_q, irq_d, done;

    logic             cfg_we, start_wr, stg2, src_clip_unused, dst_clip;
    logic [7:0]       src_sx, src_sy, dst_sx_unused, dst_sy_unused, pix;
    logic [FB_AW-1:0] src_fb_unused, dst_fb;

    assign cfg_we   = bus.reg_we && (state_q == IDLE);
    assign start_wr = cfg_we && (bus.reg_addr == REG_CTRL) && bus.reg_din[CTRL_START];

    always_ff @(posedge clk or posedge reset_gametank) begin
        if (reset_gametank) begin
            vx_q <= '0; vy_q <= '0; gx_q <= '0; gy_q <= '0;
            w_q <= '0; h_q <= '0; flipx_q <= 1'b0; flipy_q <= 1'b0;
            fill_q <= 1'b0; opaque_q <= 1'b0; bank_sel_q <= 1'b0;
            color_q <= '0; bank_q <= '0;
        end else if (cfg_we) begin
            case (bus.reg_addr)
                REG_VX:     vx_q <= bus.reg_din;
                REG_VY:     vy_q <= bus.reg_din;
                REG_GX:     gx_q <= bus.reg_din;
                REG_GY:     gy_q <= bus.reg_din;
                REG_WIDTH:  {flipx_q, w_q} <= bus.reg_din;
                REG_HEIGHT: {flipy_q, h_q} <= bus.reg_din;
                REG_CTRL: begin
                    fill_q     <= bus.reg_din[CTRL_FILL];
                    opaque_q   <= bus.reg_din[CTRL_OPAQUE];
                    bank_sel_q <= bus.reg_din[CTRL_BANK_SEL];
                end
                default: begin
                    if (bank_sel_q) bank_q  <= bus.reg_din[BANK_W-1:0];
                    else            color_q <= bus.reg_din;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_gametank) begin
        if (reset_gametank) begin
            state_q <= IDLE; i_q <= '0; j_q <= '0;
            p_valid_q <= 1'b0; p_i_q <= '0; p_j_q <= '0; irq_q <= 1'b0;
        end else begin
            state_q <= state_d; i_q <= i_d; j_q <= j_d;
            p_valid_q <= p_valid_d; p_i_q <= p_i_d; p_j_q <= p_j_d; irq_q <= irq_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        p_valid_d = p_valid_q;
        p_i_d     = p_i_q;
        p_j_d     = p_j_q;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_wr) begin
                    if (w_q != 7'd0 && h_q != 7'd0) begin
                        state_d   = RUN;
                        i_d       = '0;
                        j_d       = '0;
                        p_valid_d = 1'b0;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.ce) begin
                    p_valid_d = 1'b1;
                    p_i_d     = i_q;
                    p_j_d     = j_q;
                    if (i_q == w_q - 7'd1) begin
                        i_d = '0;
                        if (j_q == h_q - 7'd1) state_d = DRAIN;
                        else                   j_d = j_q + 7'd1;
                    end else begin
                        i_d = i_q + 7'd1;
                    end
                end
            end
            DRAIN: begin
                if (bus.ce) begin
                    p_valid_d = 1'b0;
                    state_d   = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Completion has priority over a simultaneous acknowledge.
        irq_d = done ? 1'b1 : (bus.irq_ack ? 1'b0 : irq_q);
    end

    gametank_blit_addr #(.FB_W(FB_W), .FB_H(FB_H), .FB_AW(FB_AW)) u_src (
        .base_x_i(gx_q), .base_y_i(gy_q), .i_i(i_q), .j_i(j_q),
        .w_i(w_q), .h_i(h_q), .flip_x_i(flipx_q), .flip_y_i(flipy_q),
        .sx_o(src_sx), .sy_o(src_sy), .fb_addr_o(src_fb_unused), .clip_o(src_clip_unused)
    );

    gametank_blit_addr #(.FB_W(FB_W), .FB_H(FB_H), .FB_AW(FB_AW)) u_dst (
        .base_x_i(vx_q), .base_y_i(vy_q), .i_i(p_i_q), .j_i(p_j_q),
        .w_i(w_q), .h_i(h_q), .flip_x_i(1'b0), .flip_y_i(1'b0),
        .sx_o(dst_sx_unused), .sy_o(dst_sy_unused), .fb_addr_o(dst_fb), .clip_o(dst_clip)
    );

    assign pix  = fill_q ? color_q : bus.gram_din;
    assign stg2 = p_valid_q && bus.ce;

    assign bus.busy      = (state_q != IDLE);
    assign bus.irq_done  = irq_q;
    assign bus.gram_addr = {bank_q, src_sy, src_sx};
    assign bus.gram_rd   = (state_q == RUN) && bus.ce && !fill_q;
    assign bus.fb_addr   = dst_fb;
    // Source 0x00 is transparent in copy mode unless OPAQUE is set.
    assign bus.fb_we     = stg2 && !dst_clip && (fill_q || opaque_q || (pix != 8'h00));
    assign bus.fb_dout   = p_valid_q ? pix : 8'h00;

endmodule

// File: doc/gametank_blitter.md
Name: gametank_blitter

Overview:
- Parametrised rectangular byte-copy engine ("blitter") for the GameTank video subsystem.
- Copies a W×H block from graphics RAM to the framebuffer at one pixel per `ce`. It adds three things over a plain copy: solid-colour fill, per-axis flip, and an optional opaque mode.
- Sits between the CPU register window and the GRAM/framebuffer memory ports. Bus arbitration upstream supplies `ce` (nominally 3.5 MHz) and raises `irq_done` to the CPU IRQ OR-tree.

Parameters:
- FB_W, 128: framebuffer width in pixels; power of two, ≤256.
- FB_H, 128: framebuffer height in pixels; power of two, ≤256.
- BANK_W, 3: GRAM bank bits; source address width is BANK_W+16 (default 19 bits = 512 KB).
- FB_AW, 14: framebuffer address width; equals log2(FB_W·FB_H).

Ports:
- clk  in  1  system clock
- reset_gametank  in  1  asynchronous, active-high reset
- ce  in  1  blit step enable; one pixel step per asserted cycle
- reg_we  in  1  CPU register write strobe
- reg_addr  in  3  register select
- reg_din  in  8  register write data
- busy  out  1  blit in progress
- irq_done  out  1  completion interrupt, level
- irq_ack  in  1  clears irq_done
- gram_addr  out  BANK_W+16  source address {bank, sy, sx}
- gram_rd  out  1  source read strobe
- gram_din  in  8  source data, valid on the ce step after gram_rd
- fb_addr  out  FB_AW  destination address y·FB_W+x
- fb_we  out  1  framebuffer write strobe, one cycle, coincident with a ce step
- fb_dout  out  8  pixel written

Behaviour:
- Register map, written only when busy=0; writes while busy are dropped:
  - 0 VX
  - 1 VY
  - 2 GX
  - 3 GY
  - 4 WIDTH: bits[6:0]=width, bit7=flipX
  - 5 HEIGHT: bits[6:0]=height, bit7=flipY
  - 6 CTRL: bit0=START (self-clearing), bit1=FILL, bit2=OPAQUE
  - 7 COLOR: FILL colour (bits 2:0 = BANK on write to addr 7 with CTRL.bit3 set, else colour)
- Reset: busy=0, irq_done=0, gram_rd=0, fb_we=0, all registers 0, outputs 0.
- States:
  - IDLE: a START write with width≠0 and height≠0 loads counters i=0, j=0 and goes to RUN. A START with width=0 or height=0 sets irq_done the next cycle, busy stays 0.
  - RUN, on each ce:
    - Stage 1 issues a read for (i,j): sx=GX+(flipX ? W-1-i : i), sy=GY+(flipY ? H-1-j : j), both mod 256 within BANK.
    - Stage 2, one ce later, writes the data for the previously issued pixel.
    - i increments and wraps to 0 at W, then j increments.
    - After the last pixel is issued, go to DRAIN.
  - DRAIN: on the next ce, complete stage 2, then busy=0 and irq_done=1, return to IDLE.
- FILL: gram_rd is held 0 and stage 2 writes COLOR; timing is identical to copy.
- Transparency: in copy mode with OPAQUE=0, a source byte 0x00 suppresses fb_we. FILL always writes.
- Clipping: dx=VX+i and dy=VY+j are computed 9 bits wide. dx≥FB_W or dy≥FB_H suppresses fb_we; no wrap-around.
- Latency: busy rises the cycle after the START write. The first fb_we comes on the 2nd ce after START. Total is W·H+1 ce steps.
- ce low freezes all state; outputs hold, strobes deassert.
- irq_ack clears irq_done. If irq_ack and completion land in the same cycle, completion wins (irq_done=1).
- reset_gametank mid-blit aborts immediately to IDLE; no further fb_we occurs.

Decomposition:
- Package gametank_pkg holds:
  - register address localparams (REG_VX…REG_COLOR);
  - CTRL bit indices;
  - state enum {IDLE, RUN, DRAIN}.
- One sub-module, gametank_blit_addr: combinational flip/offset/clip computation returning sx, sy, fb_addr, clip. It is instantiated for the stage-1 source calculation and the stage-2 destination calculation.

Test Plan:
- Copy: GX=0, GY=0, W=4, H=2, VX=10, VY=20, GRAM pattern 1..8, ce every cycle → 8 fb_we at addresses 20·128+10..13 and 21·128+10..13, data 1..8. busy lasts 9 ce. irq_done=1 afterwards.
- FlipX + transparency: W=4 flipX, source row {0,5,6,7}, OPAQUE=0 → writes 7,6,5 to x=VX..VX+2; x=VX+3 has no fb_we. With OPAQUE=1 the bench additionally sees 0 written at VX+3.
- Fill + clip: FILL, COLOR=0x3C, VX=126, W=4, H=1 → exactly 2 writes of 0x3C (x=126,127), gram_rd never asserted, completion still after 5 ce.
- Zero size and busy writes: START with W=0 → no fb_we, irq_done set within 2 cycles. Write VX during a 16-pixel blit → destination unchanged, new VX ignored.
- ce gating: ce asserted 1 cycle in 4 → same write sequence as scenario 1, each fb_we aligned to a ce cycle.
- Reset mid-blit: assert reset_gametank after 3 writes → busy=0, irq_done=0, no further fb_we. A new START afterwards runs correctly.
